dff_bank_arbiter: RTL
=====================

# dff_bank_arbiter

Round-robin arbiter and write sequencer for a shared W-bit D flip-flop register. It lets N requesters take turns writing into the single storage register: one owner at a time, with a bounded burst length and no idle cycle between owners. It sits in front of the shared register and owns its clock-enable, data mux and clear; downstream logic reads `q`, `q_src` and `wr`.

## Interface
- `N`, 4: number of requesters (2..8).
- `W`, 8: data width of the shared register.
- `HOLD`, 2: maximum consecutive writes per grant (>=1).

- `clk` in 1: single clock, all state updates on rising edge.
- `reset` in 1: asynchronous, active-low (0 = reset), clears all state immediately.
- `req` in N: per-requester write request, level, held until served or withdrawn.
- `wdata` in N*W: requester k data at bits [k*W +: W].
- `gnt` out N: registered one-hot grant; all-zero when idle.
- `q` out W: shared register contents.
- `q_src` out clog2(N): index of requester that performed the last write.
- `wr` out 1: registered pulse, high for the cycle after each write.
- `busy` out 1: high while state is OWN (decoded from the state register).

## Operation
- Two-state FSM: IDLE and OWN. Registers: `ptr` (clog2(N)), owner `k`, write count `cnt` (clog2(HOLD+1)).
- Arbitration: search `req` starting at `ptr` and wrap modulo N. The first set bit wins.
- IDLE: on an edge with any `req` set, grant the winner: `gnt`<=onehot(winner), `cnt`<=0, go to OWN. Otherwise hold with `gnt`=0.
- OWN, owner k, on each edge:
  - Write: if `req[k]`=1, then `q`<=`wdata[k]`, `q_src`<=k, `wr`<=1, `cnt`<=`cnt`+1. Otherwise `wr`<=0.
  - Release when `req[k]`=0, or when this edge's write makes `cnt`+1 == HOLD.
  - On release: `ptr`<=(k+1) mod N, then re-arbitrate in the same edge using the new `ptr`. k competes at lowest priority.
  - If there is a winner, grant it with `cnt`<=0 and stay in OWN (no bubble). If there is none, `gnt`<=0 and go to IDLE.
- A dropped `req[k]` produces no write on that edge.
- A requester can only write while its `gnt` bit is high. `wdata` of non-owners is ignored.
- `req` changes from non-owners never preempt the current owner.

## Timing
- Reset values: `gnt`=0, `q`=0, `q_src`=0, `wr`=0, `busy`=0, `ptr`=0, `cnt`=0, state IDLE.
- Request-to-grant latency, from IDLE: `req` set before edge E0 gives `gnt` high after E0.
- First write occurs at E1, so `q` is valid after E1: 2 edges from request to data.
- Steady contention: every edge performs exactly one write.
- The grant changes on the edge of the HOLD-th write of the current owner.
- With `req[k]` low at release, `gnt` moves on that edge without writing.
- Single requester: it is re-granted to itself on release. `gnt` stays set, `cnt` restarts, and writes continue every edge.
- Reset asserted mid-burst: all outputs clear asynchronously without waiting for `clk`. The in-flight write is lost. The first edge after deassertion arbitrates from `ptr`=0.
- Reset deasserted: behave as IDLE on the next edge.
- `wr` is 1 only for the cycle after a write edge. Back-to-back writes hold `wr` high continuously.

## Test plan
- Reset: hold `reset`=0 with `req`=4'b1111 for 3 edges. Then `gnt`=0, `q`=0, `busy`=0, `wr`=0. Release reset: `gnt`=4'b0001 after the first edge.
- Single requester 2, `wdata[2]`=8'hA5, HOLD=2: `gnt`=4'b0100 after E0. `q`=8'hA5, `q_src`=2, `wr`=1 after E1. `gnt` stays 4'b0100 across E2 (self re-grant). Drop `req`: `gnt`=0 and `busy`=0 one edge later.
- All four requesting, `wdata[k]`=8'h10+k: grant sequence 0,1,2,3,0, each for exactly 2 edges. `q` runs 10,10,11,11,12,12,13,13,10 with no gap in `wr`.
- Early withdrawal: requesters 1 and 3 request, 1 is granted and drops `req` after one write. At that edge there is no write, `wr`=0, and `gnt`=4'b1000. Next `q`=`wdata[3]`.
- Asynchronous reset mid-burst: pulse `reset` low between edges while `gnt`=4'b0010, `q`=8'h5A. `gnt`, `q`, `wr` and `busy` go to 0 before the next edge. After release with `req`=4'b0110, `gnt`=4'b0010.
- Fairness: requester 0 requests permanently and requester 3 requests once. Requester 3 is granted at the first release of 0 and completes HOLD writes before 0 is re-granted.

Source files
------------

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter and write sequencer for one shared W-bit register.
// N requesters take turns owning the register for at most HOLD writes, with no idle cycle between owners.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | no owner, gnt=0, arbitrating from ptr on every edge
// ST_OWN  | owner_q holds the grant; writes while its req stays high
module dff_bank_arbiter #(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter int HOLD = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic [N*W-1:0]       wdata,
  output logic [N-1:0]         gnt,
  output logic [W-1:0]         q,
  output logic [$clog2(N)-1:0] q_src,
  output logic                 wr,
  output logic                 busy
);

  localparam int PW = $clog2(N);
  localparam int CW = $clog2(HOLD + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_OWN  = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [W-1:0]  data_q, data_d;
  logic [PW-1:0] src_q, src_d;
  logic          wr_q, wr_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] owner_q, owner_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          own;
  logic          wr_en;
  logic          hit_hold;
  logic          release_own;
  logic [PW-1:0] next_ptr;
  logic [PW-1:0] arb_start;
  logic [PW-1:0] arb_idx;
  logic          arb_found;
  logic [N-1:0]  arb_onehot;
  logic [W-1:0]  owner_data;

  assign own         = (state_q == ST_OWN);
  assign owner_data  = wdata[owner_q*W +: W];
  assign wr_en       = own && req[owner_q];
  assign hit_hold    = wr_en && ((cnt_q + CW'(1)) == CW'(HOLD));
  assign release_own = own && (!req[owner_q] || hit_hold);
  assign next_ptr    = (owner_q == PW'(N - 1)) ? '0 : owner_q + PW'(1);
  // On release the search starts just past the old owner, so it competes last.
  assign arb_start   = release_own ? next_ptr : ptr_q;

  always_comb begin : arbitrate
    int cand;
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = 0;
    for (int i = 0; i < N; i++) begin
      cand = (int'(arb_start) + i) % N;
      if (!arb_found && req[PW'(cand)]) begin
        arb_found = 1'b1;
        arb_idx   = PW'(cand);
      end
    end
  end

  assign arb_onehot = {{(N-1){1'b0}}, 1'b1} << arb_idx;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    data_d  = data_q;
    src_d   = src_q;
    wr_d    = 1'b0;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    if (state_q == ST_IDLE) begin
      if (arb_found) begin
        state_d = ST_OWN;
        owner_d = arb_idx;
        gnt_d   = arb_onehot;
        cnt_d   = '0;
      end else begin
        gnt_d = '0;
      end
    end else begin
      if (wr_en) begin
        data_d = owner_data;
        src_d  = owner_q;
        wr_d   = 1'b1;
        cnt_d  = cnt_q + CW'(1);
      end
      if (release_own) begin
        ptr_d = next_ptr;
        cnt_d = '0;
        if (arb_found) begin
          owner_d = arb_idx;
          gnt_d   = arb_onehot;
        end else begin
          gnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      data_q  <= '0;
      src_q   <= '0;
      wr_q    <= 1'b0;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      data_q  <= data_d;
      src_q   <= src_d;
      wr_q    <= wr_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt   = gnt_q;
  assign q     = data_q;
  assign q_src = src_q;
  assign wr    = wr_q;
  assign busy  = own;

endmodule
